// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields plus a 32-bit signed immediate
// into an instruction word, range-checks the immediate for its format and
// streams the result through a two-stage valid/ready pipeline. Each output
// word carries a sequential memory address for the program loader.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          ZERO_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] out_addr,
  output logic        range_err
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;

  // Upper-bit masks: a value fits an N-bit signed field when every bit
  // from N-1 upward is a copy of the sign.
  localparam logic [31:0] MASK_S12 = 32'hFFFF_F800;
  localparam logic [31:0] MASK_S13 = 32'hFFFF_F000;
  localparam logic [31:0] MASK_S21 = 32'hFFF0_0000;

  // True when v sign-extends cleanly from the field described by mask.
  function automatic logic sext_fits(input logic [31:0] v, input logic [31:0] mask);
    logic [31:0] upper;
    upper = v & mask;
    return (upper == mask) || (upper == 32'd0);
  endfunction

  // Stage 1 state: raw captured fields.
  logic        s1_valid_r;
  logic [2:0]  s1_fmt_r;
  logic [6:0]  s1_opcode_r;
  logic [4:0]  s1_rd_r;
  logic [4:0]  s1_rs1_r;
  logic [4:0]  s1_rs2_r;
  logic [2:0]  s1_funct3_r;
  logic [6:0]  s1_funct7_r;
  logic [31:0] s1_imm_r;

  // Stage 2 state: packed word, error flag and address.
  logic        s2_valid_r;
  logic [31:0] instr_r;
  logic        err_r;
  logic [31:0] addr_r;

  logic        s2_adv_s;
  logic        is_shift_s;
  logic [31:0] packed_s;
  logic        err_s;
  logic [31:0] word_s;

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign in_ready  = !s1_valid_r || s2_adv_s;
  assign out_valid = s2_valid_r;
  assign instr     = instr_r;
  assign range_err = err_r;
  assign out_addr  = addr_r;

  // Pack the stage-1 fields for the selected format and flag bad immediates.
  always_comb begin
    packed_s   = 32'd0;
    err_s      = 1'b0;
    is_shift_s = (s1_opcode_r == OP_IMM) &&
                 ((s1_funct3_r == 3'b001) || (s1_funct3_r == 3'b101));
    case (s1_fmt_r)
      FMT_R: begin
        packed_s = {s1_funct7_r, s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
        err_s    = 1'b0;
      end
      FMT_I: begin
        if (is_shift_s) begin
          packed_s = {s1_funct7_r, s1_imm_r[4:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
          err_s    = |s1_imm_r[31:5];
        end else begin
          packed_s = {s1_imm_r[11:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
          err_s    = !sext_fits(s1_imm_r, MASK_S12);
        end
      end
      FMT_S: begin
        packed_s = {s1_imm_r[11:5], s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_imm_r[4:0], s1_opcode_r};
        err_s    = !sext_fits(s1_imm_r, MASK_S12);
      end
      FMT_B: begin
        packed_s = {s1_imm_r[12], s1_imm_r[10:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                    s1_imm_r[4:1], s1_imm_r[11], s1_opcode_r};
        err_s    = !sext_fits(s1_imm_r, MASK_S13) || s1_imm_r[0];
      end
      FMT_U: begin
        packed_s = {s1_imm_r[31:12], s1_rd_r, s1_opcode_r};
        err_s    = |s1_imm_r[11:0];
      end
      FMT_J: begin
        packed_s = {s1_imm_r[20], s1_imm_r[10:1], s1_imm_r[11], s1_imm_r[19:12],
                    s1_rd_r, s1_opcode_r};
        err_s    = !sext_fits(s1_imm_r, MASK_S21) || s1_imm_r[0];
      end
      default: begin
        packed_s = 32'd0;
        err_s    = 1'b1;
      end
    endcase
    if (err_s && (ZERO_ON_ERR != 1'b0)) begin
      word_s = NOP_WORD;
    end else begin
      word_s = packed_s;
    end
  end

  // Stage 1: capture raw fields whenever the input handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_fmt_r    <= 3'd0;
      s1_opcode_r <= 7'd0;
      s1_rd_r     <= 5'd0;
      s1_rs1_r    <= 5'd0;
      s1_rs2_r    <= 5'd0;
      s1_funct3_r <= 3'd0;
      s1_funct7_r <= 7'd0;
      s1_imm_r    <= 32'd0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_fmt_r    <= fmt;
        s1_opcode_r <= opcode;
        s1_rd_r     <= rd;
        s1_rs1_r    <= rs1;
        s1_rs2_r    <= rs2;
        s1_funct3_r <= funct3;
        s1_funct7_r <= funct7;
        s1_imm_r    <= imm;
      end
    end
  end

  // Stage 2: register the packed word, hold it under backpressure, and
  // step the address after each completed output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      instr_r    <= 32'd0;
      err_r      <= 1'b0;
      addr_r     <= BASE_ADDR;
    end else begin
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          instr_r <= word_s;
          err_r   <= err_s;
        end
      end
      if (s2_valid_r && out_ready) begin
        addr_r <= addr_r + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases from the word
// examples, backpressure, address wrap, mid-stream reset, and a random
// phase scored against a behavioural encoding model.
module tb_instr_encoder;

  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_ready;

  logic        in_ready, out_valid, range_err;
  logic [31:0] instr, out_addr;
  logic        in_ready1, out_valid1, range_err1;
  logic [31:0] instr1, out_addr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [31:0] ea0, ea1;

  bit          lit_pending;
  logic [31:0] lit_instr;
  logic        lit_err;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .ZERO_ON_ERR(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .out_addr(out_addr), .range_err(range_err)
  );

  instr_encoder #(.BASE_ADDR(BASE1), .ZERO_ON_ERR(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid1), .out_ready(out_ready), .instr(instr1),
    .out_addr(out_addr1), .range_err(range_err1)
  );

  // Behavioural reference: {error, word} straight from the format rules,
  // using signed integer ranges.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im, input bit zero);
    longint v;
    logic [31:0] w;
    bit e;
    v = longint'($signed(im));
    case (f)
      3'd0: begin w = {f7, s2, s1, f3, d, op}; e = 1'b0; end
      3'd1: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = {f7, im[4:0], s1, f3, d, op};
          e = (v < 0) || (v > 31);
        end else begin
          w = {im[11:0], s1, f3, d, op};
          e = (v < -2048) || (v > 2047);
        end
      end
      3'd2: begin w = {im[11:5], s2, s1, f3, im[4:0], op}; e = (v < -2048) || (v > 2047); end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin w = {im[31:12], d, op}; e = (v % 4096 != 0); end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin w = 32'd0; e = 1'b1; end
    endcase
    if (e && zero) w = 32'h0000_0013;
    return {e, w};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, update the scoreboard on
  // handshakes, then advance to the next falling edge.
  task automatic step(output bit acc);
    logic [32:0] e;
    #1;
    acc = 1'b0;
    check("in_ready_match", 32'(in_ready1), 32'(in_ready));
    if (out_valid) begin
      if (q0.size() == 0) begin
        check("spurious_out0", 32'(out_valid), 32'd0);
      end else begin
        e = q0[0];
        check("instr0", instr, e[31:0]);
        check("err0", 32'(range_err), 32'(e[32]));
        check("addr0", out_addr, ea0);
      end
      if (lit_pending) begin
        check("lit_instr", instr, lit_instr);
        check("lit_err", 32'(range_err), 32'(lit_err));
        lit_pending = 1'b0;
      end
    end
    if (out_valid1) begin
      if (q1.size() == 0) begin
        check("spurious_out1", 32'(out_valid1), 32'd0);
      end else begin
        e = q1[0];
        check("instr1", instr1, e[31:0]);
        check("err1", 32'(range_err1), 32'(e[32]));
        check("addr1", out_addr1, ea1);
      end
    end
    if (!rst) begin
      if (out_valid && out_ready && q0.size() > 0) begin void'(q0.pop_front()); ea0 += 32'd4; end
      if (out_valid1 && out_ready && q1.size() > 0) begin void'(q1.pop_front()); ea1 += 32'd4; end
      if (in_valid && in_ready) begin
        q0.push_back(ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, 1'b1));
        q1.push_back(ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, 1'b0));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      q0.delete(); q1.delete();
      ea0 = 32'h0000_0000; ea1 = BASE1;
    end
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic send();
    bit a;
    a = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !a; i++) step(a);
    check("accept_timeout", 32'(a), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] li, input logic le);
    bit a;
    lit_pending = 1'b1; lit_instr = li; lit_err = le;
    out_ready = 1'b1;
    send();
    for (int i = 0; i < 10 && lit_pending; i++) step(a);
    check("lit_seen", 32'(lit_pending), 32'd0);
  endtask

  task automatic drain();
    bit a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step(a);
    check("drain0", 32'(q0.size()), 32'd0);
    check("drain1", 32'(q1.size()), 32'd0);
  endtask

  task automatic rand_fields();
    int bnd[18] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                    1048574, 1048575, 1048576, -1048576, -1048578, 31, 32, 0, -1};
    fmt    = 3'($urandom_range(0, 7));
    opcode = ($urandom_range(0, 1) == 1) ? 7'h13 : 7'($urandom);
    rd     = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 80)) - 32'd40;
      2: imm = 32'(bnd[$urandom_range(0, 17)]);
      default: imm = $urandom & 32'hFFFF_F000;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int accepts;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lit_pending = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    ea0 = 32'h0000_0000; ea1 = BASE1;
    @(negedge clk);
    step(a); step(a);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", 32'(range_err), 32'd0);
    check("rst_addr0", out_addr, 32'h0000_0000);
    check("rst_addr1", out_addr1, BASE1);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1, x0, 5 with explicit latency checks
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    out_ready = 1'b1; in_valid = 1'b1;
    step(a);
    check("t1_accept", 32'(a), 32'd1);
    in_valid = 1'b0;
    #1;
    check("t1_lat1", 32'(out_valid), 32'd0);
    step(a);
    check("t1_lat2", 32'(out_valid), 32'd1);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_err", 32'(range_err), 32'd0);
    check("t1_addr", out_addr, 32'h0000_0000);
    drain();

    set_fields(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    run_one(32'h0020_A423, 1'b0);
    set_fields(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    run_one(32'hFFDF_F0EF, 1'b0);
    set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    run_one(32'h1234_52B7, 1'b0);
    set_fields(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    run_one(32'h0000_0013, 1'b1);
    set_fields(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3);
    run_one(32'h4030_D093, 1'b0);
    set_fields(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd32);
    run_one(32'h0000_0013, 1'b1);
    set_fields(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    run_one(32'h0000_0013, 1'b1);
    set_fields(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    run_one(32'h0000_0013, 1'b1);
    drain();

    // Backpressure: four words offered while the sink is stalled
    out_ready = 1'b0; in_valid = 1'b1; accepts = 0;
    for (int c = 0; c < 8; c++) begin
      set_fields(3'd1, 7'h13, 5'(accepts + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(accepts * 100));
      step(a);
      if (a) accepts++;
    end
    check("bp_accepts", 32'(accepts), 32'd2);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && accepts < 4; c++) begin
      set_fields(3'd1, 7'h13, 5'(accepts + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(accepts * 100));
      step(a);
      if (a) accepts++;
    end
    check("bp_all_accepted", 32'(accepts), 32'd4);
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step(a);
    end
    drain();

    // Reset with both stages full and a third word being offered
    out_ready = 1'b0;
    set_fields(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 32'd0);
    send();
    send();
    in_valid = 1'b1;
    rst = 1'b1;
    step(a);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_valid1", 32'(out_valid1), 32'd0);
    check("mrst_addr0", out_addr, 32'h0000_0000);
    check("mrst_addr1", out_addr1, BASE1);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    run_one(32'h0050_0093, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
